// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//  arb_state_t : arbiter FSM state encoding
//  next_rr     : round-robin search, first set req bit after ptr (wrapping)
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Upper bound on requesters the search helper understands.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

  // Returns the first index with req set, scanning ptr+1, ptr+2, ... modulo
  // num_req. Returns ptr when no bit is set (caller qualifies with |req).
  function automatic int unsigned next_rr(input logic [MAX_REQ-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       num_req);
    int unsigned idx;
    logic        hit;
    next_rr = ptr;
    hit     = 1'b0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      idx = (ptr + off) % num_req;
      if (!hit && (off <= num_req) && req[idx[MAX_IDX_W-1:0]]) begin
        next_rr = idx;
        hit     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker used while the arbiter is idle.
//  req    : request vector
//  ptr    : index of the last owner; search starts at ptr+1
//  winner : chosen requester index (meaningful only when found=1)
//  found  : at least one request is pending
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  assign found  = |req;
  assign winner = ID_W'(next_rr(MAX_REQ'(req), 32'(ptr), NUM_REQ));

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the write port of the async FIFO among
// NUM_REQ producers in the write clock domain. The owner keeps the port for
// up to BURST_LEN beats; a full FIFO stalls the owner without losing data.
// Reset release is expected to be synchronised to clk upstream.
//  clk, rst_n : write-domain clock, async active-low reset
//  req, wdata : per-requester beat valid and data slices
//  ack        : one-hot, beat of requester i accepted this cycle
//  full       : FIFO full flag
//  fifo_w_en  : FIFO write enable, fifo_data : FIFO data_in
//  grant_id   : current owner (0 when idle), busy : burst in progress
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int unsigned      CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  RR_INIT   = ID_W'(NUM_REQ - 1);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;
  logic             accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .found  (pick_found)
  );

  // A beat moves only while the owner offers one and the FIFO has room.
  assign busy   = (state == ARB_BURST);
  assign accept = busy & req[grant_q] & ~full;

  // Arbiter FSM; burst ends after the last beat or when the owner lets go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= RR_INIT;
      grant_q  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_id;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if ((accept && (beat_cnt == LAST_BEAT)) || !req[grant_q]) begin
            state    <= ARB_IDLE;
            rr_ptr   <= grant_q;
            beat_cnt <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Owner-steered outputs; everything reads 0 outside a burst.
  always_comb begin
    ack = '0;
    if (accept) ack[grant_q] = 1'b1;
  end

  assign fifo_w_en = accept;
  assign grant_id  = busy ? grant_q : '0;
  assign fifo_data = busy ? wdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: producer model per requester,
// expected FIFO writes queued per scenario and compared against observed writes.
module tb_fifo_write_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned BL      = 4;
  localparam int unsigned DEPTH   = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    ack;
  logic                  full;
  logic                  fifo_w_en;
  logic [DW-1:0]         fifo_data;
  logic [1:0]            grant_id;
  logic                  busy;

  fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .ack       (ack),
    .full      (full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Producer model: per-requester beat FIFO, req held while beats remain.
  logic [DW-1:0] beats [NUM_REQ][DEPTH];
  int            head  [NUM_REQ];
  int            tail  [NUM_REQ];

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  int checks = 0;
  int errors = 0;

  logic         s_wen, s_busy;
  logic [3:0]   s_ack;
  logic [1:0]   s_grant;
  logic [DW-1:0] s_data;

  task automatic load(input int id, input logic [DW-1:0] d, input bit expect_write);
    beats[id][tail[id]] = d;
    tail[id]++;
    if (expect_write) exp_q.push_back({6'd0, 2'(id), d});
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = (head[i] != tail[i]);
      wdata[i*DW +: DW] = (head[i] != tail[i]) ? beats[i][head[i]] : '0;
    end
  endtask

  // One cycle: sample at negedge, retire acked beats, re-drive after posedge.
  task automatic tick();
    @(negedge clk);
    s_wen   = fifo_w_en;
    s_busy  = busy;
    s_ack   = ack;
    s_grant = grant_id;
    s_data  = fifo_data;
    if (fifo_w_en) obs_q.push_back({6'd0, grant_id, fifo_data});
    for (int i = 0; i < NUM_REQ; i++)
      if (ack[i] && (head[i] != tail[i])) head[i]++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    full  = 1'b0;
    for (int b = 0; b < 8; b++) load(0, 8'(b), (b < 4));
    for (int r = 1; r < NUM_REQ; r++)
      for (int b = 0; b < 4; b++) load(r, 8'(r*16 + b), 1'b1);
    for (int b = 4; b < 8; b++) exp_q.push_back({6'd0, 2'd0, 8'(b)});
    drive();
    tick();
    tick();
    checks++; if (s_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b, expected 0000", s_ack); end
    checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b, expected 0", s_wen); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", s_busy); end
    checks++; if (s_grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d, expected 0", s_grant); end
    checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", s_data); end
    rst_n = 1'b1;
    tick();
    checks++; if (s_busy !== 1'b0 || s_wen !== 1'b0) begin errors++; $display("FAIL reset_arb_cycle: got busy=%b wen=%b, expected 0 0", s_busy, s_wen); end
    tick();
    checks++; if (s_busy !== 1'b1 || s_grant !== 2'd0) begin errors++; $display("FAIL reset_first_grant: got busy=%b grant=%0d, expected 1 0", s_busy, s_grant); end
  endtask

  task automatic test_round_robin();
    logic [15:0] o, e;
    bit eb;
    for (int c = 1; c < 25; c++) begin
      tick();
      eb = (c % 5) != 4;
      checks++; if (s_wen !== eb) begin errors++; $display("FAIL rr_wen c=%0d: got %b, expected %b", c, s_wen, eb); end
      checks++; if (s_busy !== eb) begin errors++; $display("FAIL rr_busy c=%0d: got %b, expected %b", c, s_busy, eb); end
      if (eb) begin
        checks++; if (s_grant !== 2'((c/5) % 4)) begin errors++; $display("FAIL rr_grant c=%0d: got %0d, expected %0d", c, s_grant, (c/5) % 4); end
        checks++; if (s_ack !== 4'(1 << ((c/5) % 4))) begin errors++; $display("FAIL rr_ack c=%0d: got %b, expected one-hot %0d", c, s_ack, (c/5) % 4); end
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rr_sb: got no write, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rr_sb: got %h, expected %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rr_sb_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_full_stall();
    logic [15:0] o, e;
    for (int b = 0; b < 4; b++) load(2, 8'hA0 + 8'(b), 1'b1);
    drive();
    tick();
    tick();
    tick();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (s_wen !== 1'b0 || s_ack !== 4'b0000) begin errors++; $display("FAIL stall_wen k=%0d: got wen=%b ack=%b, expected 0 0000", k, s_wen, s_ack); end
      checks++; if (s_busy !== 1'b1 || s_grant !== 2'd2) begin errors++; $display("FAIL stall_grant k=%0d: got busy=%b grant=%0d, expected 1 2", k, s_busy, s_grant); end
    end
    full = 1'b0;
    tick();
    checks++; if (s_wen !== 1'b1 || s_data !== 8'hA2) begin errors++; $display("FAIL stall_resume: got wen=%b data=%h, expected 1 a2", s_wen, s_data); end
    tick();
    tick();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL stall_end: got busy=%b, expected 0", s_busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stall_sb: got no write, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL stall_sb: got %h, expected %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stall_sb_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_early_release();
    logic [15:0] o, e;
    load(1, 8'h50, 1'b1);
    load(1, 8'h51, 1'b1);
    drive();
    tick();
    tick();
    checks++; if (s_grant !== 2'd1 || s_wen !== 1'b1) begin errors++; $display("FAIL early_grant: got grant=%0d wen=%b, expected 1 1", s_grant, s_wen); end
    tick();
    load(2, 8'h60, 1'b1);
    load(0, 8'h70, 1'b1);
    drive();
    tick();
    checks++; if (s_busy !== 1'b1 || s_wen !== 1'b0) begin errors++; $display("FAIL early_drop: got busy=%b wen=%b, expected 1 0", s_busy, s_wen); end
    tick();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL early_idle: got busy=%b, expected 0", s_busy); end
    tick();
    checks++; if (s_grant !== 2'd2 || s_data !== 8'h60) begin errors++; $display("FAIL early_next: got grant=%0d data=%h, expected 2 60", s_grant, s_data); end
    tick();
    tick();
    tick();
    checks++; if (s_grant !== 2'd0 || s_wen !== 1'b1) begin errors++; $display("FAIL early_wrap: got grant=%0d wen=%b, expected 0 1", s_grant, s_wen); end
    tick();
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL early_sb: got no write, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL early_sb: got %h, expected %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL early_sb_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_collision();
    logic [15:0] o, e;
    for (int b = 0; b < 4; b++) load(3, 8'hC0 + 8'(b), 1'b1);
    drive();
    for (int k = 0; k < 4; k++) tick();
    full = 1'b1;
    tick();
    checks++; if (s_wen !== 1'b0 || s_ack !== 4'b0000 || s_busy !== 1'b1) begin errors++; $display("FAIL coll_hold: got wen=%b ack=%b busy=%b, expected 0 0000 1", s_wen, s_ack, s_busy); end
    full = 1'b0;
    tick();
    checks++; if (s_wen !== 1'b1 || s_data !== 8'hC3 || s_ack !== 4'b1000) begin errors++; $display("FAIL coll_last: got wen=%b data=%h ack=%b, expected 1 c3 1000", s_wen, s_data, s_ack); end
    tick();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL coll_end: got busy=%b, expected 0", s_busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL coll_sb: got no write, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL coll_sb: got %h, expected %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL coll_sb_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_async_reset();
    logic [15:0] o, e;
    load(1, 8'hE0, 1'b1);
    drive();
    for (int k = 0; k < 4; k++) tick();
    load(0, 8'hD0, 1'b1);
    load(0, 8'hD1, 1'b1);
    load(0, 8'hD2, 1'b0);
    load(0, 8'hD3, 1'b0);
    drive();
    tick();
    tick();
    tick();
    checks++; if (s_grant !== 2'd0 || s_data !== 8'hD1) begin errors++; $display("FAIL areset_pre: got grant=%0d data=%h, expected 0 d1", s_grant, s_data); end
    #2;
    rst_n = 1'b0;
    load(2, 8'hF0, 1'b0);
    drive();
    #1;
    checks++; if (fifo_w_en !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL areset_wen: got wen=%b ack=%b, expected 0 0000", fifo_w_en, ack); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || fifo_data !== 8'h00) begin errors++; $display("FAIL areset_out: got busy=%b grant=%0d data=%h, expected 0 0 00", busy, grant_id, fifo_data); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back({6'd0, 2'd0, 8'hD2});
    exp_q.push_back({6'd0, 2'd0, 8'hD3});
    exp_q.push_back({6'd0, 2'd2, 8'hF0});
    tick();
    tick();
    checks++; if (s_grant !== 2'd0 || s_data !== 8'hD2) begin errors++; $display("FAIL areset_restart: got grant=%0d data=%h, expected 0 d2", s_grant, s_data); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (s_grant !== 2'd2 || s_wen !== 1'b1) begin errors++; $display("FAIL areset_next: got grant=%0d wen=%b, expected 2 1", s_grant, s_wen); end
    tick();
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL areset_sb: got no write, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL areset_sb: got %h, expected %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL areset_sb_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    rst_n = 1'b0;
    full  = 1'b0;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
